// File: rtl/ras_driver.sv
// ras_driver: single-stage fetch/decode register that drives the return address stack.
// Decodes the held instruction as call, return, conditional branch or other, issues the
// stack's push/pop/checkpoint/flush controls and forms the next-PC prediction for fetch.
// Outstanding branch checkpoints are counted so the stack's checkpoint FIFO never overflows.

module ras_driver #(
    parameter int unsigned PC_BITS    = 32,
    parameter int unsigned CKPT_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic               must_flush,
    input  logic               branch_resolved,

    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_BITS-1:0] in_pc,
    input  logic [31:0]        in_instr,

    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_BITS-1:0] out_pc,
    output logic [31:0]        out_instr,
    output logic [PC_BITS-1:0] out_pred_pc,
    output logic               out_pred_taken,

    output logic               ras_push,
    output logic               ras_pop,
    output logic               ras_is_branch,
    output logic               ras_branch_resolved,
    output logic               ras_flush,
    output logic [PC_BITS-1:0] ras_new_entry,
    input  logic [PC_BITS-1:0] ras_pc,
    input  logic               ras_empty
);

    localparam int unsigned CntW = $clog2(CKPT_DEPTH) + 1;

    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;

    localparam logic [CntW-1:0] CntFull = CntW'(CKPT_DEPTH);

    typedef enum logic [0:0] {
        StRun,
        StRecover
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e              state_q;
    logic                s1_valid_q;
    logic [PC_BITS-1:0]  s1_pc_q;
    logic [31:0]         s1_instr_q;
    logic [CntW-1:0]     ckpt_cnt_q;

    // ------------------------------------------------------------------
    // Decode of the held instruction
    // ------------------------------------------------------------------
    logic [6:0]          opcode;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic                rd_link;
    logic                rs1_link;
    logic                is_jal;
    logic                is_jalr;
    logic                is_call;
    logic                is_ret;
    logic                is_br;
    logic [20:0]         imm_j;
    logic [12:0]         imm_b;
    logic [PC_BITS-1:0]  imm_j_ext;
    logic [PC_BITS-1:0]  imm_b_ext;
    logic [PC_BITS-1:0]  pc_plus4;
    logic [PC_BITS-1:0]  ret_target;

    // Field extraction and classification; every class is qualified by s1_valid.
    always_comb begin
        opcode   = s1_instr_q[6:0];
        rd       = s1_instr_q[11:7];
        rs1      = s1_instr_q[19:15];
        rd_link  = (rd == 5'd1) || (rd == 5'd5);
        rs1_link = (rs1 == 5'd1) || (rs1 == 5'd5);

        is_jal   = s1_valid_q && (opcode == OpJal);
        is_jalr  = s1_valid_q && (opcode == OpJalr);
        is_br    = s1_valid_q && (opcode == OpBranch);
        // A link-writing JALR is a call even if rs1 is also a link (push only).
        is_call  = (is_jal && rd_link) || (is_jalr && rd_link);
        is_ret   = is_jalr && !rd_link && rs1_link;

        imm_j = {s1_instr_q[31], s1_instr_q[19:12], s1_instr_q[20], s1_instr_q[30:21], 1'b0};
        imm_b = {s1_instr_q[31], s1_instr_q[7], s1_instr_q[30:25], s1_instr_q[11:8], 1'b0};
        imm_j_ext = PC_BITS'($signed(imm_j));
        imm_b_ext = PC_BITS'($signed(imm_b));

        // Adds truncate to PC_BITS, so wrap-around is natural.
        pc_plus4   = s1_pc_q + PC_BITS'(4);
        ret_target = ras_pc & ~PC_BITS'(1);
    end

    // ------------------------------------------------------------------
    // Handshake, stall and issue
    // ------------------------------------------------------------------
    logic stall;
    logic issue;
    logic ckpt_inc;
    logic ckpt_dec;

    // Stall holds a branch once every checkpoint slot is in use; a same-cycle
    // resolve only frees the slot on the following cycle since the count is registered.
    always_comb begin
        stall     = is_br && (ckpt_cnt_q == CntFull);
        out_valid = s1_valid_q && !stall && !must_flush && (state_q == StRun);
        issue     = out_valid && out_ready;
        in_ready  = rst_n && (state_q == StRun) && !must_flush && (!s1_valid_q || issue);
        ckpt_inc  = issue && is_br;
        ckpt_dec  = branch_resolved && (ckpt_cnt_q != '0);
    end

    // ------------------------------------------------------------------
    // Prediction
    // ------------------------------------------------------------------
    logic [PC_BITS-1:0] pred_pc;
    logic               pred_taken;

    // Next-PC prediction: JAL target, stack top on a return, BTFN for branches.
    always_comb begin
        pred_pc    = pc_plus4;
        pred_taken = 1'b0;
        if (is_jal) begin
            pred_pc    = s1_pc_q + imm_j_ext;
            pred_taken = 1'b1;
        end else if (is_ret && !ras_empty) begin
            pred_pc    = ret_target;
            pred_taken = 1'b1;
        end else if (is_br && imm_b[12]) begin
            pred_pc    = s1_pc_q + imm_b_ext;
            pred_taken = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Data buses read zero while the stage is empty; stack strobes fire only on issue.
    always_comb begin
        out_pc         = s1_valid_q ? s1_pc_q    : '0;
        out_instr      = s1_valid_q ? s1_instr_q : '0;
        out_pred_pc    = s1_valid_q ? pred_pc    : '0;
        out_pred_taken = s1_valid_q && pred_taken;

        ras_push      = issue && is_call;
        // Never pop an empty stack; a return then just falls through to pc+4.
        ras_pop       = issue && is_ret && !ras_empty;
        ras_is_branch = issue && is_br;
        ras_new_entry = s1_valid_q ? pc_plus4 : '0;

        ras_flush           = must_flush;
        // A flush supersedes a same-cycle resolve: the stack restores from its flush path.
        ras_branch_resolved = ckpt_dec && !must_flush;
    end

    // ------------------------------------------------------------------
    // Sequential: FSM, pipeline register and checkpoint counter
    // ------------------------------------------------------------------
    // Flush wins over every other event: it empties the stage, clears the count and
    // parks the FSM in RECOVER for a cycle so the stack top settles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StRun;
            s1_valid_q <= 1'b0;
            s1_pc_q    <= '0;
            s1_instr_q <= '0;
            ckpt_cnt_q <= '0;
        end else if (must_flush) begin
            state_q    <= StRecover;
            s1_valid_q <= 1'b0;
            ckpt_cnt_q <= '0;
        end else begin
            unique case (state_q)
                StRun:     state_q <= StRun;
                StRecover: state_q <= StRun;
                default:   state_q <= StRun;
            endcase

            if (in_valid && in_ready) begin
                s1_valid_q <= 1'b1;
                s1_pc_q    <= in_pc;
                s1_instr_q <= in_instr;
            end else if (issue) begin
                s1_valid_q <= 1'b0;
            end

            if (ckpt_inc && !ckpt_dec) begin
                ckpt_cnt_q <= ckpt_cnt_q + CntW'(1);
            end else if (ckpt_dec && !ckpt_inc) begin
                ckpt_cnt_q <= ckpt_cnt_q - CntW'(1);
            end
        end
    end

endmodule

// File: doc/ras_driver.md
Name: ras_driver

Overview:
- Front-end control block that issues requests to the return address stack.
- Holds one fetched instruction in a single pipeline register and decodes it as call, return, conditional branch or other.
- Generates the stack's push/pop/checkpoint/flush control and the push data, and forms the next-PC prediction for fetch.
- Tracks outstanding branch checkpoints so the stack's checkpoint FIFO never overflows.

Parameters:
- PC_BITS, 32, PC width.
- CKPT_DEPTH, 4, max unresolved checkpointed branches; equals the stack's checkpoint FIFO depth.

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- must_flush  in  1  pipeline flush (mispredict); also forwarded to the stack
- branch_resolved  in  1  oldest outstanding branch resolved
- in_valid  in  1  fetch instruction valid
- in_ready  out  1  stage can accept
- in_pc  in  PC_BITS  instruction PC
- in_instr  in  32  RV32 instruction word
- out_valid  out  1  decoded instruction valid
- out_ready  in  1  downstream accepts
- out_pc  out  PC_BITS  PC of issued instruction
- out_instr  out  32  instruction word
- out_pred_pc  out  PC_BITS  predicted next PC
- out_pred_taken  out  1  prediction is not PC+4
- ras_push  out  1  stack Push
- ras_pop  out  1  stack Pop
- ras_is_branch  out  1  stack checkpoint request
- ras_branch_resolved  out  1  forwarded checkpoint release
- ras_flush  out  1  forwarded must_flush
- ras_new_entry  out  PC_BITS  return address pushed
- ras_pc  in  PC_BITS  stack top
- ras_empty  in  1  stack empty

Behaviour:
- Reset (async, rst_n low): FSM=RUN, s1_valid=0, ckpt_cnt=0. All outputs 0 except data buses, which are don't-care, driven 0.
- Stage: s1 register {valid, pc, instr}. Load on in_valid & in_ready. Latency is 1 cycle from input accept to out_valid.
- in_ready = (state==RUN) & !must_flush & (!s1_valid | issue).
- out_valid = s1_valid & !stall & !must_flush.
- issue = out_valid & out_ready. ras_push, ras_pop and ras_is_branch assert only in the issue cycle, for exactly one cycle per instruction.
- Decode (link = x1 or x5):
  - Call: JAL (opcode 1101111) with rd=link, or JALR (1100111) with rd=link. Assert ras_push; ras_new_entry = pc+4 (mod 2^PC_BITS).
  - JAL prediction: pred = pc + sext(immJ), taken=1.
  - JALR with rd=link: pred = pc+4, taken=0 (target unknown).
  - JALR with rd=link and rs1=link: treated as a call; push only, no pop.
  - Return: JALR with rd!=link and rs1=link.
    - If !ras_empty: ras_pop=1, pred = {ras_pc[PC_BITS-1:1], 1'b0}, taken=1.
    - If ras_empty: no pop, pred = pc+4, taken=0. Pop is never asserted while ras_empty=1.
  - Conditional branch (1100011): ras_is_branch=1. Static BTFN prediction: immB sign=1 gives pred = pc+sext(immB), taken=1; otherwise pc+4, taken=0.
  - Other: pred = pc+4, taken=0, no stack action.
  - ras_push and ras_pop are never both 1.
- Checkpoint counter ckpt_cnt, width $clog2(CKPT_DEPTH)+1:
  - Increments on issue of a branch.
  - Decrements on branch_resolved while ckpt_cnt>0.
  - Simultaneous increment and decrement leaves it unchanged.
  - branch_resolved with ckpt_cnt=0 is ignored and not forwarded; otherwise ras_branch_resolved = branch_resolved.
- stall = s1 holds a branch & ckpt_cnt==CKPT_DEPTH. Same-cycle branch_resolved does not lift the stall; it lifts next cycle.
- Flush:
  - must_flush=1: ras_flush=1 that cycle. No issue, s1_valid cleared, ckpt_cnt cleared, next state RECOVER.
  - RECOVER (1 cycle): in_ready=0, out_valid=0, so the stack top settles after checkpoint restore; then RUN.
  - must_flush during RECOVER: remain in RECOVER one more cycle.
  - Flush has priority over every other event, including a simultaneous branch_resolved (counter still cleared).
- Wrap-around: pc+4 and target adds truncate to PC_BITS.

Test Plan:
- JAL x1 at pc=0x100, immJ=+0x40 → issue cycle: ras_push=1, ras_new_entry=0x104, out_pred_pc=0x140, out_pred_taken=1.
- Call then return (JALR x0,0(x1)) with ras_pc=0x104, ras_empty=0 → ras_pop=1, out_pred_pc=0x104. Repeat the return with ras_empty=1 → ras_pop=0, out_pred_pc=pc+4, out_pred_taken=0.
- Five back-to-back branches with no resolution, out_ready=1 → 4 issue with ras_is_branch=1; 5th stalls (out_valid=0, in_ready=0). branch_resolved pulse → 5th issues the next cycle; ckpt_cnt ends at 4.
- Backward branch pc=0x200, immB=-8 → pred 0x1F8, taken=1. Forward immB=+8 → pred 0x204, taken=0.
- must_flush with s1 valid and ckpt_cnt=3 → ras_flush=1, no push/pop that cycle; next cycle in_ready=0; cycle after in_ready=1; ckpt_cnt=0.
- Async reset asserted mid-stream with s1 valid → out_valid=0, all ras_* outputs 0 immediately; no stale issue after release.
